rom_reader: RTL and testbench
=============================

# rom_reader

Read-side initiator for the synchronous single-port ROM (registered output, 1-cycle read latency). On a `start` command it walks a block of consecutive ROM addresses, absorbs the ROM latency, and streams the words out on a valid/ready interface with full backpressure. It sits between lookup-table ROMs (colour maps, window coefficients) and the audio-visualizer datapath.

## Interface
- `DATA_WIDTH`, 18, ROM word width and `out_data` width.
- `ADDR_WIDTH`, 3, ROM address width. ROM depth is 2^ADDR_WIDTH.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe, sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address of the block, sampled with `start`.
- `count`  in  ADDR_WIDTH+1  number of words to read, sampled with `start`. 0 is legal.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the command completes.
- `rom_addr`  out  ADDR_WIDTH  to ROM `addr`. Register output, no combinational path.
- `rom_q`  in  DATA_WIDTH  from ROM `q`. Valid the cycle after the address was presented.
- `out_data`  out  DATA_WIDTH  streamed word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts. A transfer occurs when valid and ready are both high.

## Operation
- States:
  - IDLE: `start`=1 loads the address counter with `base_addr` and the remaining-to-issue counter with `count`, then goes to READ. `start` is ignored in every other state.
  - READ: issues reads. Goes to DRAIN once the last read is issued.
  - DRAIN: waits until every issued word has been transferred, then goes to DONE.
  - DONE: pulses `done` for one cycle, drops `busy`, and returns to IDLE.
- Issue rule:
  - The ROM samples `rom_addr` every edge.
  - A read is "issued" in cycle n when in READ and `fifo_count + pending - pop_n <= 1`. Here `pending` is 1 if a read was issued in cycle n-1, and `pop_n` is a transfer in cycle n.
  - On issue, the address counter increments and the remaining-to-issue counter decrements.
- Capture: `rom_q` is written into a 2-entry FIFO at the end of the cycle after the issue. The issue rule guarantees the FIFO never overflows. Writes and pops in the same cycle are both honoured.
- The output is the FIFO head. `out_valid` = FIFO not empty.
- Address arithmetic is modulo 2^ADDR_WIDTH. A block that crosses the top address wraps to 0. If `count` exceeds the depth, addresses are reread after wrapping.
- `count`=0: IDLE → READ → DRAIN → DONE with no issue and no `out_valid`.
- `rst` at any time returns to IDLE and clears the FIFO, pending flag and counters. Reads in flight are discarded and no `done` is produced.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `rom_addr`=0.

## Timing
- Cycle 0: `start`=1 sampled.
- Cycle 1: `busy`=1, `rom_addr`=`base_addr`, first issue.
- Cycle 2: `rom_q` = mem[base].
- Cycle 3: `out_valid`=1, `out_data` = mem[base]. First-word latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle.
- `done` pulses in the cycle after the transfer of the last word, and `busy` is 0 in that same cycle.
- The earliest next `start` is accepted in the cycle after `done`.
- With `out_ready` low, `out_data` and `out_valid` are held stable. At most 2 words are buffered and issue stalls.
- No combinational path from `out_ready` to any output. `out_ready` does feed the next-state issue logic.

## Structure
- State encoding (IDLE/READ/DRAIN/DONE) lives as named constants in the shared visualizer package, next to the ROM latency constant (1).
- One sub-module: `sync_fifo2`, a 2-entry synchronous FIFO parameterized by DATA_WIDTH, with `count` output and simultaneous push/pop.
- The FSM, address counter and issue logic stay in `rom_reader`.

## Test plan
- ROM preloaded mem[i] = 18'h100+i, `out_ready`=1, start with `base_addr`=2, `count`=4 → `out_valid` in cycles 3..6 with data 102,103,104,105; `done` in cycle 7 only.
- `base_addr`=6, `count`=4 → words 106,107,100,101 (address wrap).
- `out_ready` low for cycles 3..8, then high, `base_addr`=0, `count`=8 → `out_data`=100 held stable while stalled. Exactly 8 ordered words 100..107, no loss or duplication, and `rom_addr` stops advancing while the FIFO plus pending equals 2.
- Random `out_ready` (50%), `count`=8, then back-to-back second command → scoreboard matches order. `start` pulses during `busy` are ignored. The second command is accepted in the cycle after `done`.
- `count`=0 → `done` pulse, `out_valid` never asserted, `busy` drops with `done`.
- `rst` asserted in cycle 4 of a `count`=8 run → next cycle all outputs at their reset values. No `done` follows. A new command after reset completes normally.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Shared constants for the ROM read initiator: FSM encoding, ROM latency and
// the occupancy arithmetic used by the issue throttle.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ROM_LATENCY = 1;
    localparam int FIFO_DEPTH  = 2;

    // Words that will be held after this cycle: buffered + in flight - leaving.
    function automatic logic [2:0] occupancy(input logic [1:0] fifo_count,
                                             input logic       pending,
                                             input logic       pop);
        return {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/rom_reader_sync_fifo2.sv
// Two-entry synchronous FIFO with occupancy output; a push and a pop in the
// same cycle are both honoured, even when full.
module sync_fifo2
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_reg    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] entry_next [FIFO_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic                  push_ok;
    logic                  pop_ok;

    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            assign entry_next[gi] = (push_ok && (wr_ptr_reg == 1'(gi))) ? push_data
                                                                         : mem_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next = count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Storage is cleared so the output word reads zero after reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            mem_reg    <= entry_next;
            wr_ptr_reg <= wr_ptr_reg ^ push_ok;
            rd_ptr_reg <= rd_ptr_reg ^ pop_ok;
            count_reg  <= count_next;
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/rom_reader.sv
// Walks a block of ROM addresses, absorbs the one-cycle ROM latency and streams
// the words on a valid/ready output with full backpressure.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_WIDTH:0]   remaining_reg;
    logic [ADDR_WIDTH:0]   remaining_next;
    logic                  pending_reg;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic [2:0]            level_after;

    assign pop         = out_valid && out_ready;
    assign level_after = occupancy(fifo_count, pending_reg, pop);

    // Throttle keeps buffered + in-flight words within the two FIFO slots.
    assign issue      = (state_reg == ST_READ) && (remaining_reg != '0) && (level_after <= 3'd1);
    assign last_issue = issue && (remaining_reg == (ADDR_WIDTH+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if ((remaining_reg == '0) || last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (level_after == 3'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_READ:  busy = 1'b1;
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Address wraps naturally at the ROM depth.
    always_comb begin
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        if ((state_reg == ST_IDLE) && start) begin
            addr_next      = base_addr;
            remaining_next = count;
        end else if (issue) begin
            addr_next      = addr_reg + 1'b1;
            remaining_next = remaining_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            pending_reg   <= 1'b0;
        end else begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            pending_reg   <= issue;
        end
    end

    assign rom_addr = addr_reg;

    // pending_reg marks the cycle in which rom_q holds the word issued last cycle.
    sync_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (pending_reg),
        .push_data (rom_q),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader: a behavioural ROM with mem[i] = 18'h100 + i,
// expected words queued at command time and compared on every transfer.
module tb_rom_reader;

    localparam int DW    = 18;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    rom_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_word(input int a);
        return DW'(32'h100 + (a % DEPTH));
    endfunction

    always @(posedge clk) rom_q <= exp_word(int'(rom_addr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [DW-1:0] exp_q[$];
    int            xfers = 0;
    int            first_xfer_cyc = 0;
    int            last_xfer_cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int            ready_mode = 0;
    int            stall_lo = -1;
    int            stall_hi = -1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_value("hold_valid", 32'(out_valid), 32'd1);
                check_value("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (xfers == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfers++;
                $display("xfer cycle %0d data %05h", cyc, out_data);
                check_value("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_value("data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                $display("done cycle %0d", cyc);
                check_value("busy_at_done", 32'(busy), 32'd0);
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    task automatic start_cmd(input int b, input int n, output int c0);
        start     = 1'b1;
        base_addr = AW'(b);
        count     = (AW+1)'(n);
        c0        = cyc;
        xfers     = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_word(b + i));
        $display("start cycle %0d base %0d count %0d", c0, b, n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int limit);
        for (int i = 0; (i < limit) && (done_cnt == prev); i++) begin
            @(posedge clk);
            #1;
        end
        check_value("done_seen", 32'(done_cnt > prev), 32'd1);
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
        check_value({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_value({tag, "_data"}, 32'(out_data), 32'd0);
        check_value({tag, "_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int pd;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic block, full throughput.
        pd = done_cnt;
        start_cmd(2, 4, c0);
        wait_done(pd, 50);
        check_value("t1_first_valid", 32'(first_xfer_cyc - c0), 32'd3);
        check_value("t1_last_valid", 32'(last_xfer_cyc - c0), 32'd6);
        check_value("t1_done_cycle", 32'(done_cyc - c0), 32'd7);
        check_value("t1_words", 32'(xfers), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check_value("t1_done_pulses", 32'(done_cnt - pd), 32'd1);

        // Wrap past the top address.
        pd = done_cnt;
        start_cmd(6, 4, c0);
        wait_done(pd, 50);
        check_value("t2_words", 32'(xfers), 32'd4);
        check_value("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure window in cycles 3..8.
        stall_lo   = cyc + 3;
        stall_hi   = cyc + 8;
        ready_mode = 2;
        pd = done_cnt;
        start_cmd(0, 8, c0);
        goto_cycle(c0 + 5);
        @(negedge clk);
        check_value("t3_stall_valid", 32'(out_valid), 32'd1);
        check_value("t3_stall_data5", 32'(out_data), 32'h100);
        check_value("t3_stall_addr5", 32'(rom_addr), 32'd2);
        goto_cycle(c0 + 8);
        @(negedge clk);
        check_value("t3_stall_data8", 32'(out_data), 32'h100);
        check_value("t3_stall_addr8", 32'(rom_addr), 32'd2);
        wait_done(pd, 60);
        check_value("t3_words", 32'(xfers), 32'd8);
        check_value("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Random backpressure, ignored starts while busy, back-to-back command.
        ready_mode = 1;
        pd = done_cnt;
        start_cmd(3, 8, c0);
        base_addr = 3'd7;
        count     = 4'd2;
        start     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(pd, 200);
        check_value("t4a_words", 32'(xfers), 32'd8);
        pd = done_cnt;
        start_cmd(5, 5, c1);
        @(negedge clk);
        check_value("t4b_busy_next", 32'(busy), 32'd1);
        wait_done(pd, 200);
        check_value("t4b_words", 32'(xfers), 32'd5);
        check_value("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length command.
        ready_mode = 0;
        @(posedge clk);
        #1;
        pd = done_cnt;
        start_cmd(4, 0, c0);
        wait_done(pd, 20);
        check_value("t5_done_cycle", 32'(done_cyc - c0), 32'd3);
        check_value("t5_words", 32'(xfers), 32'd0);

        // Reset in the middle of a run.
        start_cmd(0, 8, c0);
        goto_cycle(c0 + 4);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_midreset");
        pd = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check_value("t6_no_done", 32'(done_cnt - pd), 32'd0);
        start_cmd(1, 3, c0);
        wait_done(pd, 50);
        check_value("t6_words", 32'(xfers), 32'd3);
        check_value("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
